rotate_right_state_machine: RTL and testbench
=============================================

// Module: rotate_right_state_machine
// PURPOSE
//  Instruction sequencer for the 64-bit rotate-right primitive. It is the counterpart of the rotate-left sequencer and shares its instruction bus.
//  A 64-bit operand is held in RAM as four 16-bit words at {address_i, 2'bxx}. Rotate-right by n is issued as rotate-left by m = (64 - n) mod 64.
//  - m[3:0]: number of single-bit ALU left rotates (opcode 3).
//  - m[5:4]: word offset, applied as an address remap during four store cycles (opcode 2).
//  Driven by the instruction dispatcher; drives the shared 21-bit instruction bus only while active.
// PARAMETERS
//  INSTR_W  21  instruction width; fixed by bus format, not for override
//  NOP_OP   4'hC  ALU opcode presented on the start-cycle-less idle word
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   synchronous reset, ACTIVE-LOW (rst_i==0 resets)
//  bits_i         in   6   rotate-right amount n, 0..63 (parameter 1)
//  address_i      in   6   operand base address, RAM word addr = {address_i, idx[1:0]} (parameter 2)
//  start_i        in   1   request; honoured only in IDLE
//  instruction_o  out  21  {save_core=0, ram_write, addr[7:0], in_sel=2'b0, out_sel=0, out_en=0, alu_op[3:0], gcmd=3'b0}
//  busy_o         out  1   high from the cycle after accepted start through the done_o cycle
//  done_o         out  1   one-cycle pulse on the final store instruction
// BEHAVIOUR
//  Reset (rst_i==0 at edge):
//  - state <= IDLE; counters cleared.
//  - done_o=0, busy_o=0; instruction_o=Z while in reset, even if start_i is high.
//  Bus ownership:
//  - instruction_o is Z in IDLE with start_i low. It is driven in the start cycle and in every non-IDLE state.
//  Start cycle (IDLE & start_i):
//  - Latch n, address_i, m = (7'd64 - n) & 6'h3F.
//  - First instruction is issued combinationally from the live inputs in this same cycle.
//  - bits_i/address_i are don't-care afterwards.
//  Instruction kinds:
//  - ROT: ram_write=0, addr=0, op=4'h3.
//  - STO(k): ram_write=1, addr={A, k+off} with 2-bit wrap, op=4'h2, where off=m[5:4].
//  - Store order is k = 0, 3, 2, 1 (datapath shift-out order; mandatory).
//  States: IDLE, ROTATE, STORE0, STORE3, STORE2, STORE1.
//  - IDLE: on start, emit ROT if m[3:0]!=0 (cnt <= m[3:0]-1), else emit STO(0).
//    - m[3:0]==0: go to STORE3.
//    - m[3:0]==1: go to STORE0.
//    - otherwise: go to ROTATE.
//  - ROTATE: emit ROT; cnt-- ; leave to STORE0 in the cycle cnt reaches 1 (exactly m[3:0] ROTs total, start cycle included).
//  - STORE0 -> STORE3 -> STORE2 -> STORE1 -> IDLE; each emits its STO(k).
//  - STORE1 additionally asserts done_o.
//  Latency: m[3:0] + 4 cycles from the start cycle through the done cycle inclusive. Maximum 19 (m[3:0]=15).
//  Boundaries:
//  - n=0 and n=32 are valid (m=0 and m=32).
//  - start_i while busy is ignored; start_i in the done cycle is ignored.
//  - A new start is accepted on the first IDLE cycle after done.
//  - rst_i low mid-sequence aborts; no done_o is produced.
//  Width: m uses 7-bit subtract truncated to 6 bits. Address offset add is mod 4.
// STRUCTURE
//  Shared package (isa_pkg):
//  - ALU_OP_ROTL1=4'h3, ALU_OP_STORE16=4'h2, ALU_OP_NOP=4'hC.
//  - INSTR_W=21 and the instruction field layout.
//  - A pack function mk_instr(ram_write, addr, op), also to be used by the rotate-left sequencer.
//  No sub-module: FSM plus 4-bit counter plus latched operand registers inline.
// TESTING
//  1. n=0, A=6'h05, start 1 cycle -> STO addrs 8'h14,8'h17,8'h16,8'h15; done_o on 4th cycle; no ROT issued.
//  2. n=1, A=6'h01 -> 15 ROT words (21'h000018 each) then STO 8'h07,8'h06,8'h05,8'h04; done at cycle 19.
//  3. n=20, A=0 -> m=44: 12 ROTs, then STO 8'h02,8'h01,8'h00,8'h03; done cycle 16; busy_o high cycles 2..16.
//  4. n=63, A=6'h3F -> m=1: 1 ROT in start cycle, then STO 8'hFC,8'hFF,8'hFE,8'hFD; done cycle 5.
//  5. Pulse start_i again mid-sequence; change bits_i/address_i after start -> sequence unchanged, no second run.
//  6. rst_i=0 in the 3rd ROT cycle -> next cycle IDLE, instruction_o Z, done_o never asserted; a fresh start after release completes normally.
//  Checker: instruction_o is Z whenever IDLE and start_i low; the software model compares {ROT count, store addrs} against rotr(n).

Source files
------------

// File: rtl/rotate_right_state_machine_pkg.sv
// Instruction-set definitions shared by the rotate sequencers: ALU opcodes,
// the 21-bit instruction word layout and helpers that build instruction words.
package rotate_right_state_machine_pkg;

    localparam int INSTR_W = 21;

    localparam logic [3:0] ALU_OP_ROTL1   = 4'h3;
    localparam logic [3:0] ALU_OP_STORE16 = 4'h2;
    localparam logic [3:0] ALU_OP_NOP     = 4'hC;
    localparam logic [3:0] NOP_OP         = ALU_OP_NOP;

    // Field layout of the instruction bus, MSB first.
    typedef struct packed {
        logic       save_core;
        logic       ram_write;
        logic [7:0] addr;
        logic [1:0] in_sel;
        logic       out_sel;
        logic       out_en;
        logic [3:0] alu_op;
        logic [2:0] gcmd;
    } instr_t;

    // Pack an instruction word; every field not controlled by a sequencer is zero.
    function automatic logic [INSTR_W-1:0] mk_instr(input logic       ram_write,
                                                    input logic [7:0] addr,
                                                    input logic [3:0] op);
        instr_t w;
        w.save_core = 1'b0;
        w.ram_write = ram_write;
        w.addr      = addr;
        w.in_sel    = 2'b00;
        w.out_sel   = 1'b0;
        w.out_en    = 1'b0;
        w.alu_op    = op;
        w.gcmd      = 3'b000;
        return w;
    endfunction

    // RAM word address of 16-bit slice k after applying the word offset (mod 4).
    function automatic logic [7:0] store_addr(input logic [5:0] base,
                                              input logic [1:0] k,
                                              input logic [1:0] off);
        logic [1:0] idx;
        idx = k + off;
        return {base, idx};
    endfunction

endpackage

// File: rtl/rotate_right_state_machine_if.sv
// Dispatcher <-> rotate-right sequencer handshake: request with operands,
// busy/done status back. The instruction bus itself is a shared tri-state net
// and therefore stays a plain port on the sequencer.
interface rotate_right_state_machine_if;

    logic       start_i;
    logic [5:0] bits_i;
    logic [5:0] address_i;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i,
        output bits_i,
        output address_i,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  bits_i,
        input  address_i,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/rotate_right_state_machine.sv
// Rotate-right sequencer. Rotate-right by n is issued as rotate-left by
// m = (64 - n) mod 64: m[3:0] single-bit ALU rotates, then four 16-bit stores
// whose word addresses are remapped by m[5:4]. Stores go out in the order
// k = 0, 3, 2, 1, matching the datapath shift-out order.
module rotate_right_state_machine
    import rotate_right_state_machine_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    rotate_right_state_machine_if.slave ctl,
    output wire  [INSTR_W-1:0]          instruction_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ROTATE = 3'd1;
    localparam logic [2:0] ST_STORE0 = 3'd2;
    localparam logic [2:0] ST_STORE3 = 3'd3;
    localparam logic [2:0] ST_STORE2 = 3'd4;
    localparam logic [2:0] ST_STORE1 = 3'd5;

    localparam logic [INSTR_W-1:0] ROT_WORD = 21'h000018;

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic [5:0]         base_q,  base_d;
    logic [1:0]         off_q,   off_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [6:0]         m_wide_s;
    logic [5:0]         m_s;
    logic [INSTR_W-1:0] instr_s;
    logic               drive_s;

    // Rotate-left amount from the live request: 7-bit subtract truncated to 6 bits.
    always_comb begin
        m_wide_s = 7'd64 - {1'b0, ctl.bits_i};
        m_s      = m_wide_s[5:0];
    end

    // Next-state, operand latching and the instruction word for this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        off_d   = off_q;
        instr_s = mk_instr(1'b0, 8'h00, NOP_OP);
        case (state_q)
            ST_IDLE: begin
                if (ctl.start_i) begin
                    base_d = ctl.address_i;
                    off_d  = m_s[5:4];
                    if (m_s[3:0] != 4'd0) begin
                        // First rotate goes out in the start cycle itself.
                        instr_s = ROT_WORD;
                        cnt_d   = m_s[3:0] - 4'd1;
                        if (m_s[3:0] == 4'd1) begin
                            state_d = ST_STORE0;
                        end else begin
                            state_d = ST_ROTATE;
                        end
                    end else begin
                        // No rotates: first store uses the live operands.
                        instr_s = mk_instr(1'b1,
                                           store_addr(ctl.address_i, 2'd0, m_s[5:4]),
                                           ALU_OP_STORE16);
                        cnt_d   = 4'd0;
                        state_d = ST_STORE3;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                // cnt_q counts the rotates still owed, this one included.
                instr_s = ROT_WORD;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_STORE0;
                end else begin
                    state_d = ST_ROTATE;
                end
            end
            ST_STORE0: begin
                instr_s = mk_instr(1'b1, store_addr(base_q, 2'd0, off_q), ALU_OP_STORE16);
                state_d = ST_STORE3;
            end
            ST_STORE3: begin
                instr_s = mk_instr(1'b1, store_addr(base_q, 2'd3, off_q), ALU_OP_STORE16);
                state_d = ST_STORE2;
            end
            ST_STORE2: begin
                instr_s = mk_instr(1'b1, store_addr(base_q, 2'd2, off_q), ALU_OP_STORE16);
                state_d = ST_STORE1;
            end
            ST_STORE1: begin
                instr_s = mk_instr(1'b1, store_addr(base_q, 2'd1, off_q), ALU_OP_STORE16);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STORE1);
    end

    // Bus is owned in the start cycle and in every active state, never in reset.
    always_comb begin
        drive_s = rst_i && ((state_q != ST_IDLE) || ctl.start_i);
    end

    // State, counter, latched operands and registered status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            base_q  <= 6'd0;
            off_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            off_q   <= off_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction_o = drive_s ? instr_s : {INSTR_W{1'bz}};
    assign ctl.busy_o    = busy_q;
    assign ctl.done_o    = done_q;

endmodule

// File: tb/tb_rotate_right_state_machine.sv
// Bench for the rotate-right sequencer: directed table, reset abort sequence
// and randomized runs checked cycle by cycle against a rotr(n) word-list model.
module tb_rotate_right_state_machine;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    rotate_right_state_machine_if ifc();
    // The shared bus idles high through a pull-up, so a released bus reads all ones.
    tri1 [20:0] instr_w;

    localparam logic [31:0] RELEASED = 32'h001FFFFF;

    rotate_right_state_machine dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ctl           (ifc),
        .instruction_o (instr_w)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          n;
        int          a;
        bit          disturb;
        int          exp_rots;
        logic [31:0] exp_addrs;
        int          exp_done;
    } vec_t;

    // Reference model output: expected bus word per cycle of one sequence.
    logic [20:0] exp_w [0:31];
    int          exp_len;

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // rotr(n) as rotl(m): m mod 16 single rotates, then stores in order 0,3,2,1.
    task automatic build_model(input int n, input int a);
        int m;
        int rots;
        int off;
        int addr;
        int ord [4];
        ord  = '{0, 3, 2, 1};
        m    = (64 - n) % 64;
        rots = m % 16;
        off  = m / 16;
        exp_len = 0;
        for (int r = 0; r < rots; r++) begin
            exp_w[exp_len] = 21'(3 << 3);
            exp_len++;
        end
        for (int j = 0; j < 4; j++) begin
            addr = a * 4 + ((ord[j] + off) % 4);
            exp_w[exp_len] = 21'((1 << 19) | (addr << 11) | (2 << 3));
            exp_len++;
        end
    endtask

    // One start-to-done sequence, optionally with extra start pulses and operand churn.
    task automatic run_seq(input int n, input int a, input bit disturb, input bit b2b,
                           output int rots, output logic [31:0] addrs, output int done_at);
        build_model(n, a);
        rots    = 0;
        addrs   = 32'h0;
        done_at = -1;
        for (int i = 0; i < exp_len; i++) begin
            @(posedge clk);
            #1;
            ifc.start_i = (i == 0) || (disturb && (i == 2 || i == exp_len - 1));
            if (i == 0) begin
                ifc.bits_i    = 6'(n);
                ifc.address_i = 6'(a);
            end else if (disturb) begin
                ifc.bits_i    = 6'($urandom);
                ifc.address_i = 6'($urandom);
            end
            @(negedge clk);
            check("instr", i, 32'(instr_w), 32'(exp_w[i]));
            check("busy", i, 32'(ifc.busy_o), 32'(i != 0));
            check("done", i, 32'(ifc.done_o), 32'(i == exp_len - 1));
            if (instr_w[19]) begin
                addrs = {addrs[23:0], instr_w[18:11]};
            end else if (instr_w[6:3] == 4'h3) begin
                rots++;
            end
            if (ifc.done_o) begin
                done_at = i;
            end
        end
        if (!b2b) begin
            @(posedge clk);
            #1;
            ifc.start_i = 1'b0;
            @(negedge clk);
            check("idle_bus", exp_len, 32'(instr_w), RELEASED);
            check("idle_busy", exp_len, 32'(ifc.busy_o), 32'd0);
            check("idle_done", exp_len, 32'(ifc.done_o), 32'd0);
        end
    endtask

    initial begin
        vec_t        tab [5];
        int          rots;
        int          done_at;
        logic [31:0] addrs;
        int          rn;
        int          ra;

        tab[0] = '{n: 0,  a: 6'h05, disturb: 1'b0, exp_rots: 0,  exp_addrs: 32'h14171615, exp_done: 3};
        tab[1] = '{n: 1,  a: 6'h01, disturb: 1'b0, exp_rots: 15, exp_addrs: 32'h07060504, exp_done: 18};
        tab[2] = '{n: 20, a: 6'h00, disturb: 1'b0, exp_rots: 12, exp_addrs: 32'h02010003, exp_done: 15};
        tab[3] = '{n: 63, a: 6'h3F, disturb: 1'b0, exp_rots: 1,  exp_addrs: 32'hFCFFFEFD, exp_done: 4};
        tab[4] = '{n: 32, a: 6'h2A, disturb: 1'b1, exp_rots: 0,  exp_addrs: 32'hAAA9A8AB, exp_done: 3};

        // Reset with start held high: bus released, status low.
        rst_i         = 1'b0;
        ifc.start_i   = 1'b1;
        ifc.bits_i    = 6'd5;
        ifc.address_i = 6'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus", 0, 32'(instr_w), RELEASED);
        check("rst_busy", 0, 32'(ifc.busy_o), 32'd0);
        check("rst_done", 0, 32'(ifc.done_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i       = 1'b1;
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("idle_bus", 0, 32'(instr_w), RELEASED);

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            run_seq(tab[t].n, tab[t].a, tab[t].disturb, 1'b0, rots, addrs, done_at);
            check("tab_rots", t, 32'(rots), 32'(tab[t].exp_rots));
            check("tab_addrs", t, addrs, tab[t].exp_addrs);
            check("tab_done_cyc", t, 32'(done_at), 32'(tab[t].exp_done));
        end

        // Reset in the third rotate cycle aborts the sequence.
        @(posedge clk);
        #1;
        ifc.start_i   = 1'b1;
        ifc.bits_i    = 6'd20;
        ifc.address_i = 6'd3;
        @(negedge clk);
        check("abort_rot0", 0, 32'(instr_w), 32'h18);
        @(posedge clk);
        #1;
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("abort_busy", 1, 32'(ifc.busy_o), 32'd1);
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        ifc.start_i = 1'b1;
        @(negedge clk);
        check("abort_bus_rst", 2, 32'(instr_w), RELEASED);
        @(posedge clk);
        #1;
        rst_i       = 1'b1;
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("abort_bus", 3, 32'(instr_w), RELEASED);
        check("abort_busy", 3, 32'(ifc.busy_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("abort_no_done", 4 + i, 32'(ifc.done_o), 32'd0);
        end
        run_seq(20, 3, 1'b0, 1'b0, rots, addrs, done_at);
        check("after_abort_rots", 0, 32'(rots), 32'd12);
        check("after_abort_addrs", 0, addrs, 32'h0E0D0C0F);

        // Randomized runs, including back-to-back starts on the first IDLE cycle.
        for (int t = 0; t < 40; t++) begin
            rn = int'($urandom_range(0, 63));
            ra = int'($urandom_range(0, 63));
            run_seq(rn, ra, 1'($urandom), 1'($urandom), rots, addrs, done_at);
            check("rnd_rots", t, 32'(rots), 32'(((64 - rn) % 64) % 16));
            check("rnd_done_cyc", t, 32'(done_at), 32'(((64 - rn) % 64) % 16 + 3));
        end
        @(posedge clk);
        #1;
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("final_bus", 0, 32'(instr_w), RELEASED);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
